rv32i_encoder: RTL and testbench
================================

// Module: rv32i_encoder
// PURPOSE
// - Inverse of the instruction decoder: takes RV32I instruction fields over a valid/ready handshake.
// - Packs them into 32-bit machine words and streams the words into instruction memory at incrementing addresses.
// - Used by the self-test and program-loader path to build benchmark programs on-chip.
// - Out-of-range immediates are rejected and counted. They are never written.
// PARAMETERS
// - BASE_ADDR  32'h0000_0000  byte address of the first word written
// - DEPTH      1024           capacity in words; loader stops when full
// - CNT_W      11             width of word/error counters (>= clog2(DEPTH+1))
// PORTS
// - clk         in   1   clock, rising edge
// - rst_n       in   1   asynchronous active-low reset
// - start       in   1   pulse: clear counters, begin session at BASE_ADDR
// - in_valid    in   1   field bundle valid
// - in_ready    out  1   encoder accepts bundle this cycle
// - in_fmt      in   3   0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
// - in_opcode   in   7   opcode[6:0], copied to word[6:0]
// - in_funct3   in   3   word[14:12] (R/I/S/B only)
// - in_funct7   in   7   word[31:25] (R only)
// - in_rd/in_rs1/in_rs2  in  5 each  register numbers
// - in_imm      in   32  full signed immediate (byte offset for B/J, full value for U)
// - in_last     in   1   final bundle of the session
// - imem_we     out  1   write request (valid)
// - imem_ready  in   1   memory accepts the write this cycle
// - imem_addr   out  32  byte address, word aligned
// - imem_wdata  out  32  encoded instruction
// - word_cnt    out  CNT_W  words written this session
// - err_cnt     out  CNT_W  bundles rejected this session
// - full        out  1   word_cnt == DEPTH
// - done        out  1   session finished (last handled, or full)
// BEHAVIOUR
// - Reset values: all outputs 0. State = IDLE. Address register = BASE_ADDR.
// - FSM states:
//   - IDLE: start -> RUN, with counters cleared and addr = BASE_ADDR.
//   - RUN: bundle with in_last accepted -> DRAIN.
//   - DRAIN: output register empty -> DONE.
//   - DONE: done=1; start -> RUN (clears counters and done).
// - start while in RUN or DRAIN: pending output is discarded, imem_we drops, session restarts at BASE_ADDR next cycle.
// - in_ready = (state==RUN) & ~full_pending & (~imem_we | imem_ready).
//   - full_pending: word_cnt plus the held word equals DEPTH.
// - Handshake: bundle accepted when in_valid & in_ready.
//   - Encoded word appears on imem_wdata with imem_we=1 the next cycle. Latency 1.
//   - imem_we/addr/wdata stay stable until imem_ready.
//   - Back-to-back throughput is 1 word/cycle while imem_ready=1.
// - Write completes (imem_we & imem_ready):
//   - imem_addr += 4; wraps to BASE_ADDR after DEPTH words (unreachable while full gating works).
//   - word_cnt += 1.
// - Encoding (standard RV32I):
//   - R = f7|rs2|rs1|f3|rd|op
//   - I = imm[11:0]|rs1|f3|rd|op
//   - S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//   - B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
//   - U = imm[31:12]|rd|op
//   - J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
// - Reject rules (checked in the accept cycle):
//   - I/S: imm not sign-extension of imm[11:0].
//   - B: imm not sign-extension of imm[12:0], or imm[0]=1.
//   - J: imm not sign-extension of imm[20:0], or imm[0]=1.
//   - U: imm[11:0] != 0.
//   - Any format: fmt 6 or 7.
// - Rejected bundle: still handshaken, no write, err_cnt += 1 (saturates).
//   - A rejected in_last bundle still ends the session.
// - Full: word_cnt reaching DEPTH forces done=1 and state DONE. Later bundles are not accepted.
// - Simultaneous start and in_valid: start wins; bundle not accepted that cycle.
// TESTING
// - ADDI x1,x0,5 (fmt I, op 0x13, f3 0, imm 5) -> wdata 0x00500093 at addr BASE, word_cnt=1.
// - ADD x3,x1,x2, then SW x2,8(x1) back-to-back with imem_ready=1 -> 0x002081B3 then 0x0020A423 on consecutive cycles, addr +4.
// - LUI x5,0x12345000 -> 0x123452B7. JAL x1,+2048 -> 0x001000EF. imem_ready low 3 cycles -> outputs held stable, in_ready=0.
// - BEQ imm=3, I-type imm=2048, LUI imm=0x1 -> no write, err_cnt=3, word_cnt unchanged.
// - DEPTH=4 build, 6 bundles offered -> 4 writes at BASE..BASE+12, full=1, done=1, in_ready stays 0.
// - rst_n low mid-stream with imem_we=1 -> outputs 0 immediately. start mid-session -> restart at BASE, counters 0.

Source files
------------

// File: rtl/rv32i_encoder.sv
// rv32i_encoder
// Packs RV32I instruction field bundles into 32-bit machine words and streams
// them into instruction memory at incrementing word addresses. Bundles whose
// immediates cannot be represented in their format are consumed but not
// written, and they are counted in err_cnt.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                pulse: clear counters, restart the session at BASE_ADDR
//   in_valid/in_ready    field-bundle handshake
//   in_fmt .. in_last    instruction fields (fmt 0=R 1=I 2=S 3=B 4=U 5=J)
//   imem_we/imem_ready   write handshake towards instruction memory
//   imem_addr/imem_wdata write address (byte, word aligned) and encoded word
//   word_cnt, err_cnt    words written / bundles rejected in this session
//   full, done           session capacity reached / session finished
//   dbg_state            current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Once valid is raised it, and its payload, stay
// unchanged until that edge. Ready may depend combinationally on the other
// side's signals but valid never depends on ready.
module rv32i_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             imem_we,
    input  logic             imem_ready,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             full,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [31:0]      LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    logic [1:0]       state_q,    state_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             we_q,       we_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic [31:0] enc_word;
    logic        imm_bad;
    logic        full_pending;
    logic        write_done;
    logic        accept;

    // Field packing and immediate range checks.
    always_comb begin
        enc_word = '0;
        imm_bad  = 1'b0;
        case (in_fmt)
            FMT_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                imm_bad  = (in_imm[31:11] != {21{in_imm[11]}});
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                imm_bad  = (in_imm[31:11] != {21{in_imm[11]}});
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                imm_bad  = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                imm_bad  = (in_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
                imm_bad  = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
            end
            default: begin
                imm_bad = 1'b1;
            end
        endcase
    end

    // The word still sitting in the output register counts towards capacity,
    // otherwise a bundle could be accepted that can never be written.
    assign full_pending = ((word_cnt_q + CNT_W'(we_q)) == DEPTH_C);
    assign write_done   = we_q & imem_ready;
    // start takes priority over an offered bundle.
    assign in_ready     = (state_q == ST_RUN) & ~full_pending & (~we_q | imem_ready) & ~start;
    assign accept       = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (start) begin
            state_d    = ST_RUN;
            addr_d     = BASE_ADDR;
            we_d       = 1'b0;
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (write_done) begin
                we_d       = 1'b0;
                addr_d     = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
                word_cnt_d = word_cnt_q + 1'b1;
            end
            if (accept) begin
                if (imm_bad) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                end
            end
            case (state_q)
                ST_RUN: begin
                    if (word_cnt_d == DEPTH_C) begin
                        state_d = ST_DONE;
                    end else if (accept & in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((word_cnt_d == DEPTH_C) || !we_d) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_cnt   = word_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign full       = (word_cnt_q == DEPTH_C);
    assign done       = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// tb_rv32i_encoder
// Directed bench for rv32i_encoder. Instance dut_a uses the default build
// (BASE_ADDR 0, DEPTH 1024); dut_b is a DEPTH=4 build at BASE_ADDR 0x1000 for
// the capacity scenario. Inputs change on the falling edge; outputs are read
// at the falling edge or shortly after it.
module tb_rv32i_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_b;
    logic        in_valid, in_valid_b;
    logic        in_ready, in_ready_b;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        imem_we, imem_we_b;
    logic        imem_ready, imem_ready_b;
    logic [31:0] imem_addr, imem_addr_b;
    logic [31:0] imem_wdata, imem_wdata_b;
    logic [10:0] word_cnt, err_cnt;
    logic [2:0]  word_cnt_b, err_cnt_b;
    logic        full, full_b, done, done_b;
    logic [1:0]  dbg_state, dbg_state_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv32i_encoder dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_cnt(word_cnt), .err_cnt(err_cnt),
        .full(full), .done(done), .dbg_state(dbg_state)
    );

    rv32i_encoder #(.BASE_ADDR(32'h0000_1000), .DEPTH(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we_b), .imem_ready(imem_ready_b), .imem_addr(imem_addr_b),
        .imem_wdata(imem_wdata_b), .word_cnt(word_cnt_b), .err_cnt(err_cnt_b),
        .full(full_b), .done(done_b), .dbg_state(dbg_state_b)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bundle(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic last);
        in_fmt    = fmt;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; start_b = 1'b0;
        in_valid = 1'b0; in_valid_b = 1'b0;
        imem_ready = 1'b1; imem_ready_b = 1'b1;
        set_bundle(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (imem_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %0b want 0", imem_we); end
        n_checks++; if (imem_addr !== 32'd0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
        n_checks++; if (word_cnt !== 11'd0 || err_cnt !== 11'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", word_cnt, err_cnt); end
        n_checks++; if (full !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got full %0b done %0b want 0 0", full, done); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL idle: got ready %0b state %0d want 0 0", in_ready, dbg_state); end
    endtask

    task automatic test_addi();
        pulse_start();
        n_checks++; if (dbg_state !== 2'd1 || word_cnt !== 11'd0) begin n_errors++; $display("FAIL start_run: got state %0d cnt %0d want 1 0", dbg_state, word_cnt); end
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL addi_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1) begin n_errors++; $display("FAIL addi_we: got %0b want 1", imem_we); end
        n_checks++; if (imem_wdata !== 32'h0050_0093) begin n_errors++; $display("FAIL addi_wdata: got %h want 00500093", imem_wdata); end
        n_checks++; if (imem_addr !== 32'd0) begin n_errors++; $display("FAIL addi_addr: got %h want 0", imem_addr); end
        tick();
        n_checks++; if (word_cnt !== 11'd1 || imem_we !== 1'b0) begin n_errors++; $display("FAIL addi_done: got cnt %0d we %0b want 1 0", word_cnt, imem_we); end
        n_checks++; if (imem_addr !== 32'd4) begin n_errors++; $display("FAIL addi_next_addr: got %h want 4", imem_addr); end
    endtask

    task automatic test_back_to_back();
        set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        in_valid = 1'b1;
        tick();
        set_bundle(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %0b want 1", in_ready); end
        n_checks++; if (imem_wdata !== 32'h0020_81B3 || imem_addr !== 32'd4) begin n_errors++; $display("FAIL b2b_add: got %h @%h want 002081b3 @4", imem_wdata, imem_addr); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h0020_A423 || imem_addr !== 32'd8) begin n_errors++; $display("FAIL b2b_sw: got we %0b %h @%h want 1 0020a423 @8", imem_we, imem_wdata, imem_addr); end
        n_checks++; if (word_cnt !== 11'd2) begin n_errors++; $display("FAIL b2b_cnt_mid: got %0d want 2", word_cnt); end
        tick();
        n_checks++; if (word_cnt !== 11'd3 || imem_we !== 1'b0) begin n_errors++; $display("FAIL b2b_cnt: got %0d we %0b want 3 0", word_cnt, imem_we); end
    endtask

    task automatic test_stall();
        set_bundle(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        in_valid = 1'b1;
        tick();
        set_bundle(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h1234_52B7 || imem_addr !== 32'd12) begin n_errors++; $display("FAIL stall_hold%0d: got we %0b %h @%h want 1 123452b7 @c", i, imem_we, imem_wdata, imem_addr); end
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready%0d: got %0b want 0", i, in_ready); end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'h0010_00EF || imem_addr !== 32'd16 || word_cnt !== 11'd4) begin n_errors++; $display("FAIL jal: got %h @%h cnt %0d want 001000ef @10 4", imem_wdata, imem_addr, word_cnt); end
        tick();
        n_checks++; if (word_cnt !== 11'd5 || imem_we !== 1'b0) begin n_errors++; $display("FAIL jal_cnt: got %0d we %0b want 5 0", word_cnt, imem_we); end
    endtask

    task automatic test_branch();
        set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (imem_wdata !== 32'hFE20_8EE3 || imem_addr !== 32'd20) begin n_errors++; $display("FAIL beq: got %h @%h want fe208ee3 @14", imem_wdata, imem_addr); end
        tick();
        n_checks++; if (word_cnt !== 11'd6) begin n_errors++; $display("FAIL beq_cnt: got %0d want 6", word_cnt); end
    endtask

    task automatic test_reject();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
                1: set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
                2: set_bundle(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd1, 1'b0);
                default: set_bundle(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
            endcase
            in_valid = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rej_ready%0d: got %0b want 1", k, in_ready); end
            tick();
            in_valid = 1'b0;
            n_checks++; if (imem_we !== 1'b0) begin n_errors++; $display("FAIL rej_nowrite%0d: got we %0b want 0", k, imem_we); end
            if (k == 2) begin
                n_checks++; if (err_cnt !== 11'd3) begin n_errors++; $display("FAIL rej_err3: got %0d want 3", err_cnt); end
            end
        end
        n_checks++; if (err_cnt !== 11'd4 || word_cnt !== 11'd6 || imem_addr !== 32'd24) begin n_errors++; $display("FAIL rej_final: got err %0d cnt %0d addr %h want 4 6 18", err_cnt, word_cnt, imem_addr); end
    endtask

    task automatic test_last();
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        n_checks++; if (imem_wdata !== 32'hFFF0_0113 || imem_addr !== 32'd24) begin n_errors++; $display("FAIL last_word: got %h @%h want fff00113 @18", imem_wdata, imem_addr); end
        n_checks++; if (dbg_state !== 2'd2 || done !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL last_drain: got state %0d done %0b ready %0b want 2 0 0", dbg_state, done, in_ready); end
        tick();
        n_checks++; if (done !== 1'b1 || word_cnt !== 11'd7 || in_ready !== 1'b0) begin n_errors++; $display("FAIL last_done: got done %0b cnt %0d ready %0b want 1 7 0", done, word_cnt, in_ready); end
    endtask

    task automatic test_start_mid();
        int waited;
        pulse_start();
        n_checks++; if (done !== 1'b0 || word_cnt !== 11'd0 || err_cnt !== 11'd0 || imem_addr !== 32'd0) begin n_errors++; $display("FAIL restart_done: got done %0b cnt %0d err %0d addr %h want 0 0 0 0", done, word_cnt, err_cnt, imem_addr); end
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        in_valid = 1'b1;
        tick();
        set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        tick();
        imem_ready = 1'b0;
        tick();
        // ADD is now held on the output, second ADD offered together with start.
        start = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0 || imem_we !== 1'b1) begin n_errors++; $display("FAIL start_wins: got ready %0b we %0b want 0 1", in_ready, imem_we); end
        tick();
        start = 1'b0;
        #1;
        n_checks++; if (imem_we !== 1'b0 || imem_addr !== 32'd0) begin n_errors++; $display("FAIL restart_clear: got we %0b addr %h want 0 0", imem_we, imem_addr); end
        n_checks++; if (word_cnt !== 11'd0 || err_cnt !== 11'd0) begin n_errors++; $display("FAIL restart_cnt: got %0d/%0d want 0/0", word_cnt, err_cnt); end
        in_valid = 1'b0;
        imem_ready = 1'b1;
        tick();
        // Rejected final bundle still ends the session.
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        waited = 0;
        while (done !== 1'b1 && waited < 5) begin
            tick();
            waited++;
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rej_last_done: got %0b want 1 within 5 cycles", done); end
        n_checks++; if (err_cnt !== 11'd1 || word_cnt !== 11'd0 || imem_we !== 1'b0) begin n_errors++; $display("FAIL rej_last_cnt: got err %0d cnt %0d we %0b want 1 0 0", err_cnt, word_cnt, imem_we); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        in_valid = 1'b1;
        imem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1) begin n_errors++; $display("FAIL rstmid_setup: got we %0b want 1", imem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_we !== 1'b0 || imem_wdata !== 32'd0 || imem_addr !== 32'd0) begin n_errors++; $display("FAIL rstmid_out: got we %0b %h @%h want 0 0 @0", imem_we, imem_wdata, imem_addr); end
        n_checks++; if (in_ready !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL rstmid_state: got ready %0b state %0d want 0 0", in_ready, dbg_state); end
        tick();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
    endtask

    task automatic test_full();
        logic [31:0] exp_w [4];
        int n_acc;
        int n_wr;
        exp_w[0] = 32'h0000_0093;
        exp_w[1] = 32'h0010_0093;
        exp_w[2] = 32'h0020_0093;
        exp_w[3] = 32'h0030_0093;
        n_acc = 0;
        n_wr  = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (imem_we_b === 1'b1) begin
                if (n_wr < 4) begin
                    n_checks++; if (imem_addr_b !== 32'h1000 + 32'(4 * n_wr) || imem_wdata_b !== exp_w[n_wr]) begin n_errors++; $display("FAIL full_write%0d: got %h @%h want %h @%h", n_wr, imem_wdata_b, imem_addr_b, exp_w[n_wr], 32'h1000 + 32'(4 * n_wr)); end
                end else begin
                    n_checks++; n_errors++; $display("FAIL full_extra_write: got write %0d @%h want at most 4", n_wr, imem_addr_b);
                end
                n_wr++;
            end
            if (n_acc < 6) begin
                set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(n_acc), 1'b0);
                in_valid_b = 1'b1;
            end else begin
                in_valid_b = 1'b0;
            end
            #1;
            if (in_valid_b && in_ready_b) n_acc++;
            tick();
        end
        in_valid_b = 1'b1;
        #1;
        n_checks++; if (n_wr !== 4 || n_acc !== 4) begin n_errors++; $display("FAIL full_counts: got writes %0d accepts %0d want 4 4", n_wr, n_acc); end
        n_checks++; if (full_b !== 1'b1 || done_b !== 1'b1 || word_cnt_b !== 3'd4) begin n_errors++; $display("FAIL full_flags: got full %0b done %0b cnt %0d want 1 1 4", full_b, done_b, word_cnt_b); end
        n_checks++; if (in_ready_b !== 1'b0 || imem_we_b !== 1'b0) begin n_errors++; $display("FAIL full_ready: got ready %0b we %0b want 0 0", in_ready_b, imem_we_b); end
        in_valid_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_branch();
        test_reject();
        test_last();
        test_start_mid();
        test_reset_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
